// File: rtl/mux_sel_arbiter_pkg.sv
// Shared encodings for the two-requester operand-mux arbiter.
package mux_sel_arbiter_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT_A = 2'd1;
  localparam logic [1:0] ST_GRANT_B = 2'd2;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IDLE = 2'b10;

  localparam logic SIDE_A = 1'b0;
  localparam logic SIDE_B = 1'b1;

  // Moore decode of the mux select from the arbiter state.
  function automatic logic [1:0] sel_of_state(input logic [1:0] st);
    case (st)
      ST_GRANT_A: sel_of_state = SEL_A;
      ST_GRANT_B: sel_of_state = SEL_B;
      default:    sel_of_state = SEL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mux_sel_arbiter_burst_counter.sv
// Beat counter for the current grant; AtLimit flags that the next beat completes a burst.
module burst_counter
  import mux_sel_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Inc,
  input  logic             Clr,
  output logic [CNT_W-1:0] Count,
  output logic             AtLimit
);

  always_ff @(posedge Clk) begin
    if (Reset || Clr) begin
      Count <= '0;
    end else if (Inc) begin
      Count <= Count + CNT_W'(1);
    end
  end

  // Compare against MAX_BURST-1 so the limiting beat can clear in the same cycle.
  always_comb begin
    AtLimit = (Count == CNT_W'(MAX_BURST - 1));
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter sharing a 2-to-1 operand mux between requesters A and B,
// with a burst limit and a registered output word.
module mux_sel_arbiter
  import mux_sel_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ReqA,
  input  logic [WIDTH-1:0] DataA,
  input  logic             ReqB,
  input  logic [WIDTH-1:0] DataB,
  output logic             GntA,
  output logic             GntB,
  output logic [1:0]       Sel,
  output logic [WIDTH-1:0] Out,
  output logic             OutValid,
  output logic             OutSrc
);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             last_served;
  logic             xfer;
  logic             cnt_inc;
  logic             cnt_clr;
  logic             at_limit;
  logic [CNT_W-1:0] burst_count;
  logic [WIDTH-1:0] mux_word;

  burst_counter #(
    .MAX_BURST (MAX_BURST)
  ) u_burst_counter (
    .Clk     (Clk),
    .Reset   (Reset),
    .Inc     (cnt_inc),
    .Clr     (cnt_clr),
    .Count   (burst_count),
    .AtLimit (at_limit)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    xfer       = 1'b0;
    cnt_inc    = 1'b0;
    cnt_clr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ReqA && (!ReqB || last_served == SIDE_B)) begin
          state_next = ST_GRANT_A;
        end else if (ReqB) begin
          state_next = ST_GRANT_B;
        end
      end
      ST_GRANT_A: begin
        if (!ReqA) begin
          cnt_clr    = 1'b1;
          state_next = ReqB ? ST_GRANT_B : ST_IDLE;
        end else begin
          xfer    = 1'b1;
          cnt_inc = 1'b1;
          // A full burst always restarts the count; hand over only if B waits.
          if (at_limit) begin
            cnt_clr = 1'b1;
            if (ReqB) begin
              state_next = ST_GRANT_B;
            end
          end
        end
      end
      ST_GRANT_B: begin
        if (!ReqB) begin
          cnt_clr    = 1'b1;
          state_next = ReqA ? ST_GRANT_A : ST_IDLE;
        end else begin
          xfer    = 1'b1;
          cnt_inc = 1'b1;
          if (at_limit) begin
            cnt_clr = 1'b1;
            if (ReqA) begin
              state_next = ST_GRANT_A;
            end
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_clr    = 1'b1;
      end
    endcase
  end

  always_comb begin
    GntA = (state == ST_GRANT_A);
    GntB = (state == ST_GRANT_B);
    Sel  = sel_of_state(state);
  end

  // Operand mux; the idle select recirculates the held output word.
  always_comb begin
    case (Sel)
      SEL_A:   mux_word = DataA;
      SEL_B:   mux_word = DataB;
      default: mux_word = Out;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Out         <= '0;
      OutValid    <= 1'b0;
      OutSrc      <= 1'b0;
      last_served <= SIDE_B;
    end else begin
      OutValid <= xfer;
      if (xfer) begin
        Out    <= mux_word;
        OutSrc <= (state == ST_GRANT_B);
      end
      if (state == ST_GRANT_A) begin
        last_served <= SIDE_A;
      end else if (state == ST_GRANT_B) begin
        last_served <= SIDE_B;
      end
    end
  end

  a_grant_onehot: assert property (@(posedge Clk) !(GntA && GntB));
  a_count_bound:  assert property (@(posedge Clk) disable iff (Reset)
                                   burst_count < CNT_W'(MAX_BURST));

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Table-driven bench for mux_sel_arbiter with a scoreboard for the registered output.
module tb_mux_sel_arbiter;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             req_a;
  logic [WIDTH-1:0] data_a;
  logic             req_b;
  logic [WIDTH-1:0] data_b;
  logic             gnt_a;
  logic             gnt_b;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_src;

  mux_sel_arbiter #(
    .WIDTH     (WIDTH),
    .MAX_BURST (4)
  ) dut (
    .Clk      (clk),
    .Reset    (reset),
    .ReqA     (req_a),
    .DataA    (data_a),
    .ReqB     (req_b),
    .DataB    (data_b),
    .GntA     (gnt_a),
    .GntB     (gnt_b),
    .Sel      (sel),
    .Out      (out),
    .OutValid (out_valid),
    .OutSrc   (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus plus the grant expected during that cycle (0 idle, 1 A, 2 B).
  typedef struct {
    logic             rst;
    logic             ra;
    logic [WIDTH-1:0] da;
    logic             rb;
    logic [WIDTH-1:0] db;
    int               g;
  } vec_t;

  typedef struct {
    logic             clear;
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             src;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] exp_out = '0;
  logic             exp_src = 1'b0;

  task automatic v(input logic rst, input logic ra, input logic [WIDTH-1:0] da,
                   input logic rb, input logic [WIDTH-1:0] db, input int g);
    vec_t t;
    t.rst = rst; t.ra = ra; t.da = da; t.rb = rb; t.db = db; t.g = g;
    vecs.push_back(t);
  endtask

  task automatic check_grant(input int cyc, input int g);
    logic       eg_a;
    logic       eg_b;
    logic [1:0] esel;
    eg_a = (g == 1);
    eg_b = (g == 2);
    esel = (g == 1) ? 2'b00 : (g == 2) ? 2'b01 : 2'b10;
    checks++;
    if (gnt_a !== eg_a || gnt_b !== eg_b || sel !== esel) begin
      errors++;
      $display("FAIL grant cyc=%0d got gnt_a=%b gnt_b=%b sel=%b exp gnt_a=%b gnt_b=%b sel=%b",
               cyc, gnt_a, gnt_b, sel, eg_a, eg_b, esel);
    end
  endtask

  task automatic check_out(input int cyc);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL out cyc=%0d scoreboard empty", cyc);
    end else begin
      e = sb.pop_front();
      if (e.clear) begin
        exp_out = '0;
        exp_src = 1'b0;
      end else if (e.valid) begin
        exp_out = e.data;
        exp_src = e.src;
      end
      if (out_valid !== e.valid || out !== exp_out || out_src !== exp_src) begin
        errors++;
        $display("FAIL out cyc=%0d got valid=%b out=%h src=%b exp valid=%b out=%h src=%b",
                 cyc, out_valid, out, out_src, e.valid, exp_out, exp_src);
      end
    end
  endtask

  task automatic push_exp(input vec_t t);
    exp_t e;
    e.clear = t.rst;
    e.valid = 1'b0;
    e.data  = '0;
    e.src   = 1'b0;
    if (!t.rst && t.g == 1 && t.ra) begin
      e.valid = 1'b1; e.data = t.da; e.src = 1'b0;
    end else if (!t.rst && t.g == 2 && t.rb) begin
      e.valid = 1'b1; e.data = t.db; e.src = 1'b1;
    end
    sb.push_back(e);
  endtask

  initial begin
    exp_t seed;

    // Reset held with both requesting; first tie then goes to A.
    v(1, 1, 4'h1, 1, 4'h2, 0);
    v(1, 1, 4'h1, 1, 4'h2, 0);
    v(0, 1, 4'h1, 1, 4'h2, 0);
    // A alone: 3,5,7 and grant holds past the burst limit.
    v(0, 1, 4'h3, 0, 4'h0, 1);
    v(0, 1, 4'h5, 0, 4'h0, 1);
    v(0, 1, 4'h7, 0, 4'h0, 1);
    v(0, 1, 4'h9, 0, 4'h0, 1);
    v(0, 1, 4'hA, 0, 4'h0, 1);
    v(0, 0, 4'h0, 0, 4'h0, 1);
    v(0, 0, 4'h0, 0, 4'h0, 0);
    // Both held: tie goes to B (A served last), 4 beats each, no gaps.
    v(0, 1, 4'h1, 1, 4'h8, 0);
    v(0, 1, 4'h1, 1, 4'h8, 2);
    v(0, 1, 4'h1, 1, 4'h9, 2);
    v(0, 1, 4'h1, 1, 4'hA, 2);
    v(0, 1, 4'h1, 1, 4'hB, 2);
    v(0, 1, 4'h1, 1, 4'h0, 1);
    v(0, 1, 4'h2, 1, 4'h0, 1);
    v(0, 1, 4'h3, 1, 4'h0, 1);
    v(0, 1, 4'h4, 1, 4'h0, 1);
    v(0, 1, 4'h0, 1, 4'hC, 2);
    // B drops after 2 beats: one dead cycle, then A with a fresh count.
    v(0, 1, 4'h0, 1, 4'hD, 2);
    v(0, 1, 4'h5, 0, 4'h0, 2);
    v(0, 1, 4'h6, 1, 4'hE, 1);
    v(0, 1, 4'h7, 1, 4'hE, 1);
    v(0, 1, 4'h8, 1, 4'hE, 1);
    v(0, 1, 4'h9, 1, 4'hE, 1);
    v(0, 1, 4'h0, 1, 4'hF, 2);
    v(0, 1, 4'h0, 1, 4'h1, 2);
    v(0, 1, 4'h0, 1, 4'h2, 2);
    v(0, 1, 4'h0, 1, 4'h3, 2);
    // Reset during beat 3 of an A burst: beat dropped, tie then goes to A.
    v(0, 1, 4'hA, 1, 4'h0, 1);
    v(0, 1, 4'hB, 1, 4'h0, 1);
    v(1, 1, 4'hC, 1, 4'h0, 1);
    v(0, 1, 4'hC, 1, 4'h0, 0);
    v(0, 1, 4'hD, 0, 4'h0, 1);
    // A drops into B, then both drop: idle with Out held.
    v(0, 0, 4'h0, 1, 4'h6, 1);
    v(0, 0, 4'h0, 1, 4'h7, 2);
    v(0, 0, 4'h0, 0, 4'h0, 2);
    v(0, 0, 4'h0, 0, 4'h0, 0);
    v(0, 0, 4'h0, 0, 4'h0, 0);

    reset  = 1'b1;
    req_a  = 1'b0;
    req_b  = 1'b0;
    data_a = '0;
    data_b = '0;
    @(posedge clk);
    seed.clear = 1'b1; seed.valid = 1'b0; seed.data = '0; seed.src = 1'b0;
    sb.push_back(seed);

    for (int i = 0; i < vecs.size(); i++) begin
      #1;
      reset  = vecs[i].rst;
      req_a  = vecs[i].ra;
      data_a = vecs[i].da;
      req_b  = vecs[i].rb;
      data_b = vecs[i].db;
      push_exp(vecs[i]);
      @(negedge clk);
      check_grant(i, vecs[i].g);
      check_out(i);
      @(posedge clk);
    end

    #1;
    reset = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    @(negedge clk);
    check_grant(vecs.size(), 0);
    check_out(vecs.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
